controlador_fifo_memoria: RTL and testbench

- Upstream control stage for the 16x2 single-port memory block. It turns that memory into a 16-entry, 2-bit FIFO.
- Owns the memory's write enable, address and write-data inputs, and consumes its combinational read data.
- Arbitrates push, pop and a flush sweep onto the single address port.
- At top level, the memory's rst is tied to the same rst net.

---
 rtl/controlador_fifo_memoria.sv | 98 +++++++++
 tb/tb_controlador_fifo_memoria.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/controlador_fifo_memoria.sv
// FIFO controller that turns the 16x2 single-port memory into a 16-entry queue.
// A single address port is shared by flush sweep, pop and push, in that priority order.
module controlador_fifo_memoria #(
    parameter int ANCHO = 2,
    parameter int DIR   = 4,
    parameter int PROF  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [ANCHO-1:0] push_data,
    output logic             push_ready,
    input  logic             pop_req,
    output logic [ANCHO-1:0] pop_data,
    output logic             pop_valid,
    input  logic             flush,
    output logic             busy,
    output logic             full,
    output logic             empty,
    output logic [DIR:0]     count,
    output logic             mem_wre,
    output logic [DIR-1:0]   mem_addr,
    output logic [ANCHO-1:0] mem_din,
    input  logic [ANCHO-1:0] mem_dout
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    localparam logic [DIR:0]   PROF_C = (DIR+1)'(PROF);
    localparam logic [DIR-1:0] ULTIMA = DIR'(PROF - 1);

    logic [0:0]     state;
    logic [DIR-1:0] wr_ptr;
    logic [DIR-1:0] rd_ptr;
    logic [DIR-1:0] flush_cnt;
    logic           take_flush;
    logic           take_pop;
    logic           take_push;

    assign busy  = (state == FLUSH);
    assign full  = (count == PROF_C);
    assign empty = (count == '0);

    always_comb begin
        take_flush = (state == IDLE) && flush;
        take_pop   = (state == IDLE) && !flush && pop_req && !empty;
        push_ready = (state == IDLE) && !flush && !full && !take_pop;
        take_push  = push_valid && push_ready;

        // Idle default points at the read pointer so mem_dout is ready for a pop.
        mem_wre  = 1'b0;
        mem_addr = rd_ptr;
        mem_din  = '0;
        if (state == FLUSH) begin
            mem_wre  = 1'b1;
            mem_addr = flush_cnt;
        end else if (take_push) begin
            mem_wre  = 1'b1;
            mem_addr = wr_ptr;
            mem_din  = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            flush_cnt <= '0;
            count     <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
        end else begin
            pop_valid <= 1'b0;
            if (state == FLUSH) begin
                flush_cnt <= flush_cnt + 1'b1;
                if (flush_cnt == ULTIMA)
                    state <= IDLE;
            end else if (take_flush) begin
                state     <= FLUSH;
                flush_cnt <= '0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
            end else if (take_pop) begin
                pop_data  <= mem_dout;
                pop_valid <= 1'b1;
                rd_ptr    <= rd_ptr + 1'b1;
                count     <= count - 1'b1;
            end else if (take_push) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_controlador_fifo_memoria.sv
// Bench for controlador_fifo_memoria: directed test-plan sequences plus random traffic,
// checked against a queue-based FIFO model; a 16x2 memory model closes the loop.
module tb_controlador_fifo_memoria;

    logic       clk = 1'b0;
    logic       rst;
    logic       push_valid;
    logic [1:0] push_data;
    logic       push_ready;
    logic       pop_req;
    logic [1:0] pop_data;
    logic       pop_valid;
    logic       flush;
    logic       busy;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       mem_wre;
    logic [3:0] mem_addr;
    logic [1:0] mem_din;
    logic [1:0] mem_dout;

    always #5 clk = ~clk;

    controlador_fifo_memoria dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
        .pop_req(pop_req), .pop_data(pop_data), .pop_valid(pop_valid),
        .flush(flush), .busy(busy), .full(full), .empty(empty), .count(count),
        .mem_wre(mem_wre), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Memory block: synchronous write, combinational read, cleared by rst.
    logic [1:0] mem [16];
    assign mem_dout = mem[mem_addr];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 2'b00;
        end else if (mem_wre) begin
            mem[mem_addr] <= mem_din;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: contents in a queue, read position, remaining flush cycles.
    logic [1:0] q[$];
    int         rd_idx    = 0;
    int         busy_left = 0;
    logic       e_pv      = 1'b0;
    logic [1:0] e_pd      = 2'b00;

    task automatic step(input logic pv, input logic [1:0] pd, input logic pr,
                        input logic fl, input logic r, output logic acc);
        logic idle, e_tp, e_rdy, e_push;
        @(negedge clk);
        push_valid = pv; push_data = pd; pop_req = pr; flush = fl; rst = r;
        #1;
        idle   = (busy_left == 0);
        e_tp   = idle && !fl && pr && (q.size() > 0);
        e_rdy  = idle && !fl && (q.size() < 16) && !e_tp;
        e_push = pv && e_rdy;
        chk("push_ready", push_ready, e_rdy);
        chk("busy", busy, !idle);
        chk("count", count, q.size());
        chk("full", full, q.size() == 16);
        chk("empty", empty, q.size() == 0);
        if (!idle) begin
            chk("flush_wre", mem_wre, 1);
            chk("flush_addr", mem_addr, 16 - busy_left);
            chk("flush_din", mem_din, 0);
        end else if (e_tp) begin
            chk("pop_wre", mem_wre, 0);
            chk("pop_addr", mem_addr, rd_idx);
        end else if (e_push) begin
            chk("push_wre", mem_wre, 1);
            chk("push_addr", mem_addr, (rd_idx + q.size()) % 16);
            chk("push_din", mem_din, pd);
        end else begin
            chk("idle_wre", mem_wre, 0);
        end

        e_pv = 1'b0;
        if (r) begin
            q.delete(); rd_idx = 0; busy_left = 0; e_pd = 2'b00;
        end else if (!idle) begin
            busy_left--;
        end else if (fl) begin
            q.delete(); rd_idx = 0; busy_left = 16;
        end else if (e_tp) begin
            e_pd = q.pop_front(); e_pv = 1'b1; rd_idx = (rd_idx + 1) % 16;
        end else if (e_push) begin
            q.push_back(pd);
        end
        acc = e_push && !r;

        @(posedge clk);
        #1;
        chk("pop_valid", pop_valid, e_pv);
        chk("pop_data", pop_data, e_pd);
    endtask

    initial begin
        logic       acc;
        logic       pv;
        logic [1:0] pd;
        rst = 1'b1; push_valid = 1'b0; push_data = 2'b00; pop_req = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state, then three pushes and four pops.
        step(0, 2'b00, 0, 0, 0, acc);
        step(1, 2'b01, 0, 0, 0, acc);
        step(1, 2'b10, 0, 0, 0, acc);
        step(1, 2'b11, 0, 0, 0, acc);
        repeat (4) step(0, 2'b00, 1, 0, 0, acc);

        // Fill to 16, hold a 17th, pop once, then the wrapped push.
        for (int i = 0; i < 16; i++) step(1, 2'(i), 0, 0, 0, acc);
        step(1, 2'b10, 0, 0, 0, acc);
        step(1, 2'b10, 1, 0, 0, acc);
        step(1, 2'b10, 0, 0, 0, acc);

        // Drain to 2, then push and pop contend.
        repeat (14) step(0, 2'b00, 1, 0, 0, acc);
        step(1, 2'b01, 1, 0, 0, acc);
        step(1, 2'b01, 0, 0, 0, acc);

        // Flush with 5 entries while hammering push and pop.
        repeat (3) step(1, 2'b11, 0, 0, 0, acc);
        step(0, 2'b00, 0, 1, 0, acc);
        repeat (16) step(1, 2'b01, 1, 1, 0, acc);
        step(1, 2'b10, 0, 0, 0, acc);
        step(0, 2'b00, 1, 0, 0, acc);

        // Reset during flush cycle 7.
        repeat (3) step(1, 2'b11, 0, 0, 0, acc);
        step(0, 2'b00, 0, 1, 0, acc);
        repeat (6) step(0, 2'b00, 1, 0, 0, acc);
        step(0, 2'b00, 0, 0, 1, acc);
        step(1, 2'b01, 0, 0, 0, acc);
        step(0, 2'b00, 1, 0, 0, acc);

        // Random traffic; a stalled push holds its word.
        pv = 1'b0; pd = 2'b00; acc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!pv || acc) begin
                pv = ($urandom_range(0, 99) < 60);
                pd = 2'($urandom);
            end
            step(pv, pd, ($urandom_range(0, 99) < 40), ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 499) == 0), acc);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
